// File: rtl/axi_sram_slave_if.sv
// AXI4 subset between the L2 external bus master and the SRAM slave.
// m_* signals are driven by the master and s_* signals by the slave.
interface axi4_interface;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic        m_awvalid;
    logic        s_awready;
    logic [31:0] m_wdata;
    logic        m_wlast;
    logic        m_wvalid;
    logic        s_wready;
    logic        s_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        m_rready;

    modport slave (
        input  m_awaddr, m_awlen, m_awvalid,
        output s_awready,
        input  m_wdata, m_wlast, m_wvalid,
        output s_wready,
        output s_bvalid,
        input  m_bready,
        input  m_araddr, m_arlen, m_arvalid,
        output s_arready,
        output s_rdata, s_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst slave over a single-port word RAM, one transaction at a time (macro AXI_SRAM_LATENCY_EN adds read wait).
// Latency: first R beat 1 cycle after AR (READ_LATENCY+1 with the macro); B 1 cycle after the last W beat.
// Backpressure: R data held while m_rready=0, s_bvalid held until m_bready; W accepted every cycle of a burst.
module axi_sram_slave #(
    parameter int MEM_WORDS    = 65536,
    parameter int READ_LATENCY = 8
) (
    input logic          clk,
    input logic          reset,
    axi4_interface.slave axi_bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
`ifdef AXI_SRAM_LATENCY_EN
    localparam bit WAIT_EN = (READ_LATENCY > 0);
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_RESP} state_t;
    typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

    state_t        state;
    prio_t         rr_prio;
    logic [AW-1:0] word_addr;
    logic [7:0]    beats_left;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   mem [MEM_WORDS];

    logic          s_rvalid_q;
    logic          s_wready_q;
    logic          s_bvalid_q;
    logic [31:0]   s_rdata_q;

    logic          ar_take;
    logic          aw_take;
    logic [AW-1:0] ar_word;
    logic [AW-1:0] aw_word;
    logic          unused_bits;

    assign ar_word = axi_bus.m_araddr[AW+1:2];
    assign aw_word = axi_bus.m_awaddr[AW+1:2];
    assign unused_bits = ^{axi_bus.m_araddr[31:AW+2], axi_bus.m_araddr[1:0],
                           axi_bus.m_awaddr[31:AW+2], axi_bus.m_awaddr[1:0],
                           axi_bus.m_wlast};

    // Address arbitration: the side holding priority wins a simultaneous request.
    always_comb begin
        ar_take = (state == IDLE) && axi_bus.m_arvalid &&
                  (!axi_bus.m_awvalid || rr_prio == PRIO_READ);
        aw_take = (state == IDLE) && axi_bus.m_awvalid &&
                  (!axi_bus.m_arvalid || rr_prio == PRIO_WRITE);
    end

    assign axi_bus.s_arready = ar_take;
    assign axi_bus.s_awready = aw_take;
    assign axi_bus.s_rvalid  = s_rvalid_q;
    assign axi_bus.s_rdata   = s_rdata_q;
    assign axi_bus.s_wready  = s_wready_q;
    assign axi_bus.s_bvalid  = s_bvalid_q;

    always_ff @(posedge clk) begin
        if (state == WR_BURST && axi_bus.m_wvalid) begin
            mem[word_addr] <= axi_bus.m_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_prio    <= PRIO_READ;
            word_addr  <= '0;
            beats_left <= '0;
            wait_cnt   <= '0;
            s_rvalid_q <= 1'b0;
            s_wready_q <= 1'b0;
            s_bvalid_q <= 1'b0;
            s_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_take) begin
                        rr_prio    <= PRIO_WRITE;
                        beats_left <= axi_bus.m_arlen;
                        if (WAIT_EN) begin
                            word_addr <= ar_word;
                            wait_cnt  <= CW'(READ_LATENCY - 1);
                            state     <= RD_WAIT;
                        end else begin
                            // First beat is read straight off the request address.
                            s_rdata_q  <= mem[ar_word];
                            s_rvalid_q <= 1'b1;
                            word_addr  <= ar_word + 1'b1;
                            state      <= RD_BURST;
                        end
                    end else if (aw_take) begin
                        rr_prio    <= PRIO_READ;
                        beats_left <= axi_bus.m_awlen;
                        word_addr  <= aw_word;
                        s_wready_q <= 1'b1;
                        state      <= WR_BURST;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        s_rdata_q  <= mem[word_addr];
                        s_rvalid_q <= 1'b1;
                        word_addr  <= word_addr + 1'b1;
                        state      <= RD_BURST;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RD_BURST: begin
                    if (axi_bus.m_rready) begin
                        if (beats_left == 8'd0) begin
                            s_rvalid_q <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            // word_addr already points at the next beat.
                            s_rdata_q  <= mem[word_addr];
                            word_addr  <= word_addr + 1'b1;
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (axi_bus.m_wvalid) begin
                        word_addr <= word_addr + 1'b1;
                        if (beats_left == 8'd0) begin
                            s_wready_q <= 1'b0;
                            s_bvalid_q <= 1'b1;
                            state      <= WR_RESP;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_bus.m_bready) begin
                        s_bvalid_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: reference word model plus a queue of expected read beats.
// Covers burst write/read, arbitration alternation, read stalls, address wrap, mid-burst reset and read latency.
module tb_axi_sram_slave;
    localparam int MEM_WORDS    = 65536;
    localparam int READ_LATENCY = 8;
`ifdef AXI_SRAM_LATENCY_EN
    localparam int EXP_LAT = READ_LATENCY + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi4_interface bus();

    axi_sram_slave #(
        .MEM_WORDS(MEM_WORDS),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .axi_bus(bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [3:0]  rpat = 4'b1001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a, input int k);
        return (int'(a >> 2) + k) % MEM_WORDS;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input bit seq);
        int n;
        logic [31:0] d;
        bus.m_awaddr  = addr;
        bus.m_awlen   = 8'(len);
        bus.m_awvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.s_awready && n < 50) begin step(); n++; end
        chk("aw_accept", {31'd0, bus.s_awready}, 32'd1);
        step();
        bus.m_awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            d = seq ? 32'(k) : $urandom;
            bus.m_wdata  = d;
            bus.m_wvalid = 1'b1;
            bus.m_wlast  = (k == len);
            chk("wready_in_burst", {31'd0, bus.s_wready}, 32'd1);
            model[widx(addr, k)] = d;
            step();
        end
        bus.m_wvalid = 1'b0;
        bus.m_wlast  = 1'b0;
        chk("bvalid_after_last", {31'd0, bus.s_bvalid}, 32'd1);
        chk("wready_after_last", {31'd0, bus.s_wready}, 32'd0);
        step();
        chk("bvalid_cleared", {31'd0, bus.s_bvalid}, 32'd0);
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input bit stall, input int abort_at);
        int n, lat, got;
        logic [31:0] held;
        bit was_stalled;
        bus.m_araddr  = addr;
        bus.m_arlen   = 8'(len);
        bus.m_arvalid = 1'b1;
        bus.m_rready  = 1'b0;
        #1;
        n = 0;
        while (!bus.s_arready && n < 50) begin step(); n++; end
        chk("ar_accept", {31'd0, bus.s_arready}, 32'd1);
        for (int k = 0; k <= len; k++) exp_q.push_back(model[widx(addr, k)]);
        step();
        bus.m_arvalid = 1'b0;
        lat = 1;
        while (!bus.s_rvalid && lat < 40) begin step(); lat++; end
        chk("first_rvalid_latency", lat, EXP_LAT);
        got = 0;
        n = 0;
        held = '0;
        was_stalled = 1'b0;
        while (got <= len && n < 400) begin
            if (abort_at >= 0 && got == abort_at) begin
                reset = 1'b0;
                #1;
                chk("rvalid_async_reset", {31'd0, bus.s_rvalid}, 32'd0);
                bus.m_rready = 1'b0;
                exp_q.delete();
                return;
            end
            bus.m_rready = stall ? rpat[n % 4] : 1'b1;
            chk("rvalid_in_burst", {31'd0, bus.s_rvalid}, 32'd1);
            if (was_stalled) chk("rdata_held", bus.s_rdata, held);
            if (bus.m_rready) begin
                chk("rdata", bus.s_rdata, exp_q.pop_front());
                got++;
                was_stalled = 1'b0;
            end else begin
                held = bus.s_rdata;
                was_stalled = 1'b1;
            end
            step();
            n++;
        end
        bus.m_rready = 1'b0;
        chk("read_beats", got, len + 1);
        chk("rvalid_after_last", {31'd0, bus.s_rvalid}, 32'd0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.m_awaddr = '0; bus.m_awlen = '0; bus.m_awvalid = 1'b0;
        bus.m_wdata = '0; bus.m_wlast = 1'b0; bus.m_wvalid = 1'b0;
        bus.m_bready = 1'b1;
        bus.m_araddr = '0; bus.m_arlen = '0; bus.m_arvalid = 1'b0;
        bus.m_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid",  {31'd0, bus.s_rvalid},  32'd0);
        chk("rst_wready",  {31'd0, bus.s_wready},  32'd0);
        chk("rst_bvalid",  {31'd0, bus.s_bvalid},  32'd0);
        chk("rst_arready", {31'd0, bus.s_arready}, 32'd0);
        chk("rst_awready", {31'd0, bus.s_awready}, 32'd0);
        chk("rst_rdata",   bus.s_rdata,            32'd0);
        reset = 1'b1;
        step();

        // Sequential burst write then back-to-back readback.
        do_write(32'h1000, 15, 1'b1);
        do_read(32'h1000, 15, 1'b0, -1);

        // Readback with m_rready pattern 1,0,0,1.
        do_write(32'h2000, 7, 1'b0);
        do_read(32'h2000, 7, 1'b1, -1);

        // Burst crossing the top of RAM.
        do_write(32'((MEM_WORDS - 2) * 4), 3, 1'b0);
        do_read(32'((MEM_WORDS - 2) * 4), 3, 1'b0, -1);
        do_read(32'h0, 1, 1'b0, -1);

        // Reset during beat 5 of a 16-beat read.
        do_read(32'h1000, 15, 1'b0, 5);
        step();
        chk("post_rst_rdata", bus.s_rdata, 32'd0);
        reset = 1'b1;
        step();

        // Simultaneous requests after reset: read first, then write.
        bus.m_araddr  = 32'h1000;
        bus.m_arvalid = 1'b1;
        bus.m_awaddr  = 32'h3000;
        bus.m_awvalid = 1'b1;
        #1;
        chk("arb1_arready", {31'd0, bus.s_arready}, 32'd1);
        chk("arb1_awready", {31'd0, bus.s_awready}, 32'd0);
        bus.m_awvalid = 1'b0;
        do_read(32'h1000, 15, 1'b0, -1);
        bus.m_arvalid = 1'b1;
        bus.m_awvalid = 1'b1;
        #1;
        chk("arb2_awready", {31'd0, bus.s_awready}, 32'd1);
        chk("arb2_arready", {31'd0, bus.s_arready}, 32'd0);
        bus.m_arvalid = 1'b0;
        do_write(32'h3000, 1, 1'b0);
        do_read(32'h3000, 1, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
